pulse_dac_sink: RTL and testbench
=================================

Name: pulse_dac_sink

Overview:
Consumes the 32-bit AXI-stream sample stream produced by the pulse engine and delivers it to the DAC at a fixed sample rate. Each beat is one I/Q sample pair. The block buffers beats in a FIFO and prefills before playback. It applies a signed Q2.14 gain with saturation, and flags underflow when the DAC strobe arrives with no data during an active pulse. It sits directly downstream of the pulse engine's master AXI-stream port, inside the pulse scheduler.

Parameters:
FIFO_DEPTH, 16, FIFO entries (power of two, >= 4); each entry holds tdata[31:0] plus tlast.
PREFILL_LVL, 4, buffered words required before STREAM starts (1..FIFO_DEPTH).
SAMPLE_W, 16, width of each I and Q component; fixed at 16.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
s_axis_tdata  in  32  sample: [15:0] = I (signed), [31:16] = Q (signed).
s_axis_tvalid  in  1  upstream beat valid.
s_axis_tlast  in  1  final sample of the pulse.
s_axis_tready  out  1  beat accepted when tvalid && tready.
dac_strobe  in  1  one-cycle sample-rate enable from the DAC clocking.
gain  in  16  signed Q2.14 gain (0x4000 = 1.0); sampled on each strobe.
clear  in  1  synchronous soft clear.
dac_i  out  16  registered I output.
dac_q  out  16  registered Q output.
dac_valid  out  1  one-cycle pulse when dac_i/dac_q update.
dac_active  out  1  high while in STREAM.
underflow  out  1  sticky underflow flag.
underflow_cnt  out  16  saturating underflow count.
pulse_done  out  1  one-cycle pulse when the tlast sample is output.

Behaviour:
- Reset: FIFO empty, state IDLE, and all outputs 0 except s_axis_tready = 1.
- clear has the same effect as reset, applied on the next edge. It overrides all other events in that cycle, including a push or a strobe.
- s_axis_tready = !fifo_full. This is a combinational function of the registered count.
- A push and a pop in the same cycle are legal; the count is then unchanged. A beat is never dropped or duplicated.
- last_cnt counts tlast entries currently held in the FIFO: +1 on pushing a tlast beat, -1 on popping a tlast entry.
- States:
  - IDLE -> PREFILL on the first accepted beat.
  - PREFILL -> STREAM when count >= PREFILL_LVL or last_cnt != 0. This is evaluated on registered values, so STREAM is entered one cycle after the condition holds.
  - STREAM -> IDLE on the cycle in which a strobe pops a tlast entry.
- A strobe in IDLE or PREFILL outputs zeros: dac_valid = 1, dac_i = dac_q = 0, no pop.
- A strobe in STREAM with the FIFO non-empty:
  - pops the head entry;
  - dac_i/dac_q are registered on the next edge, giving 1-cycle latency from strobe to dac_valid;
  - pulse_done pulses in the same cycle as dac_valid if the popped entry had tlast.
- A strobe in STREAM with the FIFO empty:
  - outputs zeros with dac_valid = 1;
  - sets underflow;
  - increments underflow_cnt, saturating at 0xFFFF;
  - the state stays STREAM.
- Gain arithmetic:
  - product = signed(sample) * signed(gain), 32-bit;
  - result = product >>> 14 (arithmetic shift);
  - result is saturated to [-32768, 32767].
  - I and Q are processed independently. Zero outputs bypass the gain.
- A strobe in the same cycle as an accepted beat into an empty FIFO during STREAM is an underflow. There is no fall-through path.
- dac_active is registered and equals (state == STREAM).
- A reset asserted mid-stream discards all buffered data immediately.

Test Plan:
1. Prefill gating: push 3 beats (no tlast), strobe every 4 cycles, gain 0x4000 -> dac_valid pulses with dac_i = dac_q = 0, dac_active = 0, no pops. Push a 4th beat -> dac_active rises 1 cycle later, and the next strobe outputs beat 0 unchanged.
2. Unity gain with tlast: push beats 0xFEDC1234, 0x00010002 (tlast), gain 0x4000, strobes -> dac_i = 0x1234/dac_q = 0xFEDC, then 0x0002/0x0001 with pulse_done = 1. State returns to IDLE, and the following strobe outputs 0/0.
3. Saturation: gain 0x7FFF, I = 0x6000 -> dac_i = 0x7FFF; I = 0xA000 -> dac_i = 0x8000; gain 0x2000 with I = 0x1000 -> 0x0800.
4. Full/backpressure: FIFO_DEPTH = 16, hold tvalid high with no strobes -> exactly 16 beats accepted and tready = 0. One strobe -> tready returns to 1 one cycle after the pop, and the data order is preserved.
5. Underflow: enter STREAM with 4 beats and no tlast, then issue 6 strobes -> 4 data samples followed by 2 zero samples, underflow = 1, underflow_cnt = 2. Asserting clear returns both to 0 and the state to IDLE.
6. Async reset mid-stream: assert rst_n = 0 between edges while 5 beats are buffered -> all outputs drop to 0 immediately and tready = 1. After release, the first accepted beat restarts PREFILL.

Source files
------------

// File: rtl/pulse_dac_sink_if.sv
// AXI-stream sample link between the pulse engine and the DAC sink.
// Each beat carries one I/Q pair: [15:0] = I, [31:16] = Q, both signed.
interface pulse_dac_sink_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pulse_dac_sink.sv
// DAC sample sink: buffers I/Q beats from the pulse engine in a FIFO, waits
// for a prefill level (or a complete short pulse), then plays one sample per
// DAC strobe through a saturating Q2.14 gain stage. Strobes with no data
// while streaming produce zeros and are counted as underflows.
module pulse_dac_sink #(
    parameter int FIFO_DEPTH  = 16,
    parameter int PREFILL_LVL = 4,
    parameter int SAMPLE_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pulse_dac_sink_if.slave            s_axis,
    input  logic                       dac_strobe,
    input  logic signed [15:0]         gain,
    input  logic                       clear,
    output logic signed [SAMPLE_W-1:0] dac_i,
    output logic signed [SAMPLE_W-1:0] dac_q,
    output logic                       dac_valid,
    output logic                       dac_active,
    output logic                       underflow,
    output logic [15:0]                underflow_cnt,
    output logic                       pulse_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [31:0] SAT_MAX = 32'sd2 ** (SAMPLE_W - 1) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd2 ** (SAMPLE_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        STREAM
    } state_t;

    state_t state, next_state;

    // FIFO entry: {tlast, Q, I}
    logic [32:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, last_cnt;

    logic        full, push, pop, push_last, pop_last, underflow_evt;
    logic [32:0] head;

    // Saturating Q2.14 multiply: (sample * gain) >>> 14, clamped to sample range.
    function automatic logic signed [SAMPLE_W-1:0] apply_gain(
        input logic signed [SAMPLE_W-1:0] sample,
        input logic signed [15:0]         g
    );
        logic signed [31:0] prod;
        logic signed [31:0] shifted;
        prod    = 32'(sample) * 32'(g);
        shifted = prod >>> 14;
        if (shifted > SAT_MAX)
            return SAT_MAX[SAMPLE_W-1:0];
        else if (shifted < SAT_MIN)
            return SAT_MIN[SAMPLE_W-1:0];
        else
            return shifted[SAMPLE_W-1:0];
    endfunction

    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign s_axis.tready = ~full;
    assign head          = mem[rd_ptr];

    // clear wins over every other event in its cycle, so it gates push and pop.
    assign push      = s_axis.tvalid & ~full & ~clear;
    assign push_last = push & s_axis.tlast;
    // No fall-through: a pop needs data already registered in the FIFO.
    assign pop       = dac_strobe & ~clear & (state == STREAM) & (count != '0);
    assign pop_last  = pop & head[32];
    assign underflow_evt = dac_strobe & ~clear & (state == STREAM) & (count == '0);

    assign dac_active = (state == STREAM);

    // Sample storage; only written on an accepted beat.
    // NOTE: the array has no reset; pointers and count alone define which
    // entries are valid, so resetting the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
    end

    // FIFO pointers, occupancy and count of buffered tlast entries.
    // NOTE: all state updates use <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({push_last, pop_last})
                2'b10:   last_cnt <= last_cnt + CNT_W'(1);
                2'b01:   last_cnt <= last_cnt - CNT_W'(1);
                default: last_cnt <= last_cnt;
            endcase
        end
    end

    // Playback state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (clear)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; prefill exit uses registered count/last_cnt.
    // NOTE: next_state is defaulted first so no path leaves it unassigned.
    always_comb begin
        next_state = state;
        unique case (state)
            // Leftover beats of a following pulse also restart prefill.
            IDLE:    if (push || count != '0) next_state = PREFILL;
            PREFILL: if (count >= CNT_W'(PREFILL_LVL) || last_cnt != '0) next_state = STREAM;
            STREAM:  if (pop_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // DAC output registers, valid/done pulses and underflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_i         <= '0;
            dac_q         <= '0;
            dac_valid     <= 1'b0;
            pulse_done    <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (clear) begin
            dac_i         <= '0;
            dac_q         <= '0;
            dac_valid     <= 1'b0;
            pulse_done    <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            dac_valid  <= 1'b0;
            pulse_done <= 1'b0;
            if (dac_strobe) begin
                dac_valid <= 1'b1;
                if (pop) begin
                    dac_i      <= apply_gain(head[SAMPLE_W-1:0], gain);
                    dac_q      <= apply_gain(head[31:16], gain);
                    pulse_done <= head[32];
                end else begin
                    dac_i <= '0;
                    dac_q <= '0;
                end
            end
            if (underflow_evt) begin
                underflow <= 1'b1;
                if (underflow_cnt != 16'hFFFF)
                    underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_dac_sink.sv
// Bench for pulse_dac_sink: strobes push expected samples to a scoreboard,
// a monitor pops and compares them whenever dac_valid is seen.
module tb_pulse_dac_sink;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_dac_sink_if axis();

    logic        dac_strobe = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] gain = 16'h4000;
    logic [15:0] dac_i, dac_q, underflow_cnt;
    logic        dac_valid, dac_active, underflow, pulse_done;

    pulse_dac_sink #(
        .FIFO_DEPTH  (16),
        .PREFILL_LVL (4),
        .SAMPLE_W    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis        (axis),
        .dac_strobe    (dac_strobe),
        .gain          (gain),
        .clear         (clear),
        .dac_i         (dac_i),
        .dac_q         (dac_q),
        .dac_valid     (dac_valid),
        .dac_active    (dac_active),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .pulse_done    (pulse_done)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic        done;
    } exp_t;

    typedef struct {
        logic [15:0] g;
        logic [31:0] d;
        logic [15:0] ei;
        logic [15:0] eq;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every dac_valid must match the oldest expected sample.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (dac_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got i=0x%0h q=0x%0h want none", dac_i, dac_q);
            end else begin
                e = sb.pop_front();
                check("dac_i", 32'(dac_i), 32'(e.i));
                check("dac_q", 32'(dac_q), 32'(e.q));
                check("pulse_done", 32'(pulse_done), 32'(e.done));
            end
        end
    end

    task automatic push_beat(input logic [31:0] d, input logic l);
        int waited = 0;
        @(negedge clk);
        axis.tdata  = d;
        axis.tvalid = 1'b1;
        axis.tlast  = l;
        while (axis.tready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("push_ready", 32'(axis.tready), 32'd1);
        @(negedge clk);
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] ei, input logic [15:0] eq, input logic ed);
        @(negedge clk);
        dac_strobe = 1'b1;
        sb.push_back('{i: ei, q: eq, done: ed});
        @(negedge clk);
        dac_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_active", 32'(dac_active), 32'd0);
        check("clr_underflow", 32'(underflow), 32'd0);
        check("clr_uf_cnt", 32'(underflow_cnt), 32'd0);
        check("clr_tready", 32'(axis.tready), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t        tbl[6];
        int          n;
        logic        rdy;
        logic [15:0] nn, kk;

        tbl[0] = '{16'h7FFF, 32'h1000_6000, 16'h7FFF, 16'h1FFF};
        tbl[1] = '{16'h7FFF, 32'hF000_A000, 16'h8000, 16'hE000};
        tbl[2] = '{16'h2000, 32'hFFFF_1000, 16'h0800, 16'hFFFF};
        tbl[3] = '{16'hC000, 32'h0001_8000, 16'h7FFF, 16'hFFFF};
        tbl[4] = '{16'h4000, 32'h8000_7FFF, 16'h7FFF, 16'h8000};
        tbl[5] = '{16'h0000, 32'h5678_1234, 16'h0000, 16'h0000};

        axis.tdata  = '0;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        idle(3);

        // Reset state
        check("rst_tready", 32'(axis.tready), 32'd1);
        check("rst_valid", 32'(dac_valid), 32'd0);
        check("rst_active", 32'(dac_active), 32'd0);
        check("rst_dac_i", 32'(dac_i), 32'd0);
        check("rst_dac_q", 32'(dac_q), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        check("rst_done", 32'(pulse_done), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: prefill gating
        gain = 16'h4000;
        push_beat(32'h0011_0010, 1'b0);
        push_beat(32'h0021_0020, 1'b0);
        push_beat(32'h0031_0030, 1'b0);
        for (int k = 0; k < 3; k++) begin
            strobe(16'h0000, 16'h0000, 1'b0);
            idle(3);
            check("t1_prefill_active", 32'(dac_active), 32'd0);
        end
        push_beat(32'h0041_0040, 1'b0);
        check("t1_active_before", 32'(dac_active), 32'd0);
        @(posedge clk);
        #1;
        check("t1_active_rise", 32'(dac_active), 32'd1);
        strobe(16'h0010, 16'h0011, 1'b0);
        strobe(16'h0020, 16'h0021, 1'b0);
        strobe(16'h0030, 16'h0031, 1'b0);
        strobe(16'h0040, 16'h0041, 1'b0);
        drain();
        check("t1_underflow", 32'(underflow), 32'd0);
        do_clear();

        // 2: unity gain with tlast
        push_beat(32'hFEDC_1234, 1'b0);
        push_beat(32'h0001_0002, 1'b1);
        idle(2);
        check("t2_active", 32'(dac_active), 32'd1);
        strobe(16'h1234, 16'hFEDC, 1'b0);
        strobe(16'h0002, 16'h0001, 1'b1);
        drain();
        check("t2_back_idle", 32'(dac_active), 32'd0);
        strobe(16'h0000, 16'h0000, 1'b0);
        drain();
        check("t2_underflow", 32'(underflow), 32'd0);

        // 3: gain / saturation vectors
        for (int v = 0; v < 6; v++)
            push_beat(tbl[v].d, (v == 5));
        idle(2);
        check("t3_active", 32'(dac_active), 32'd1);
        for (int v = 0; v < 6; v++) begin
            gain = tbl[v].g;
            strobe(tbl[v].ei, tbl[v].eq, (v == 5));
        end
        drain();
        check("t3_back_idle", 32'(dac_active), 32'd0);
        gain = 16'h4000;

        // 4: full / backpressure
        n = 0;
        @(negedge clk);
        axis.tvalid = 1'b1;
        axis.tlast  = 1'b0;
        for (int c = 0; c < 24; c++) begin
            nn = n[15:0];
            axis.tdata = {16'h0A00 + nn, 16'h0500 + nn};
            rdy = axis.tready;
            @(negedge clk);
            if (rdy)
                n++;
        end
        axis.tvalid = 1'b0;
        check("t4_accepted", 32'(n), 32'd16);
        check("t4_tready_full", 32'(axis.tready), 32'd0);
        check("t4_active", 32'(dac_active), 32'd1);
        strobe(16'h0500, 16'h0A00, 1'b0);
        check("t4_tready_after_pop", 32'(axis.tready), 32'd1);
        for (int k = 1; k < 16; k++) begin
            kk = k[15:0];
            strobe(16'h0500 + kk, 16'h0A00 + kk, 1'b0);
        end
        drain();
        check("t4_underflow", 32'(underflow), 32'd0);
        do_clear();

        // 5: underflow
        for (int k = 0; k < 4; k++) begin
            kk = k[15:0];
            push_beat({16'h0200 + kk, 16'h0100 + kk}, 1'b0);
        end
        idle(2);
        check("t5_active", 32'(dac_active), 32'd1);
        for (int k = 0; k < 4; k++) begin
            kk = k[15:0];
            strobe(16'h0100 + kk, 16'h0200 + kk, 1'b0);
        end
        strobe(16'h0000, 16'h0000, 1'b0);
        strobe(16'h0000, 16'h0000, 1'b0);
        drain();
        check("t5_underflow", 32'(underflow), 32'd1);
        check("t5_uf_cnt", 32'(underflow_cnt), 32'd2);
        check("t5_still_stream", 32'(dac_active), 32'd1);
        do_clear();

        // 6: async reset mid-stream
        for (int k = 0; k < 6; k++) begin
            kk = k[15:0];
            push_beat({16'h0400 + kk, 16'h0300 + kk}, 1'b0);
        end
        idle(2);
        strobe(16'h0300, 16'h0400, 1'b0);
        drain();
        check("t6_held_i", 32'(dac_i), 32'h0300);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_dac_i", 32'(dac_i), 32'd0);
        check("t6_rst_dac_q", 32'(dac_q), 32'd0);
        check("t6_rst_active", 32'(dac_active), 32'd0);
        check("t6_rst_tready", 32'(axis.tready), 32'd1);
        check("t6_rst_valid", 32'(dac_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_beat(32'h0AAA_0555, 1'b0);
        check("t6_prefill", 32'(dac_active), 32'd0);
        strobe(16'h0000, 16'h0000, 1'b0);
        drain();
        push_beat(32'h0BBB_0666, 1'b0);
        push_beat(32'h0CCC_0777, 1'b0);
        push_beat(32'h0DDD_0888, 1'b0);
        idle(2);
        check("t6_restream", 32'(dac_active), 32'd1);
        strobe(16'h0555, 16'h0AAA, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
